// File: rtl/poly_voice_engine_if.sv
// Note-event handshake bundle for poly_voice_engine.
// The source drives the event fields and the engine returns note_ready_o.
interface poly_voice_engine_if #(
    parameter int KEY_W     = 4,
    parameter int ACC_WIDTH = 32
);
    logic                 note_valid_i;
    logic                 note_ready_o;
    logic                 note_on_i;
    logic [KEY_W-1:0]     note_key_i;
    logic [ACC_WIDTH-1:0] note_inc_i;
    logic [1:0]           note_wave_i;

    modport master (
        output note_valid_i, note_on_i, note_key_i, note_inc_i, note_wave_i,
        input  note_ready_o
    );

    modport slave (
        input  note_valid_i, note_on_i, note_key_i, note_inc_i, note_wave_i,
        output note_ready_o
    );
endinterface

// File: rtl/poly_voice_engine.sv
// Polyphonic phase-accumulator oscillator core: VOICES voices with attack/release
// envelopes, mixed one voice per cycle through a shared datapath on each sample tick.
module poly_voice_engine #(
    parameter int VOICES       = 4,
    parameter int WIDTH_P      = 24,
    parameter int ACC_WIDTH    = 32,
    parameter int KEY_W        = 4,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    poly_voice_engine_if.slave   note,
    input  logic                 sample_tick_i,
    output logic [WIDTH_P-1:0]   sample_o,
    output logic                 sample_valid_o,
    output logic [VOICES-1:0]    active_o,
    output logic                 note_drop_o,
    output logic                 overrun_o
);
    localparam int VW    = $clog2(VOICES);
    localparam int SUM_W = WIDTH_P + VW;
    localparam int PRD_W = WIDTH_P + ENV_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MIX  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [1:0] V_FREE    = 2'd0;
    localparam logic [1:0] V_ATTACK  = 2'd1;
    localparam logic [1:0] V_SUSTAIN = 2'd2;
    localparam logic [1:0] V_RELEASE = 2'd3;

    localparam logic [ENV_W-1:0]   ENV_MAX = '1;
    localparam logic [WIDTH_P-1:0] SQ_POS  = {1'b0, {(WIDTH_P-1){1'b1}}};
    localparam logic [WIDTH_P-1:0] SQ_NEG  = {1'b1, {(WIDTH_P-2){1'b0}}, 1'b1};

    logic [1:0]              fsm;
    logic [VW-1:0]           vidx;
    logic signed [SUM_W-1:0] acc;

    logic [1:0]           vstate [VOICES];
    logic [ACC_WIDTH-1:0] phase  [VOICES];
    logic [ACC_WIDTH-1:0] inc    [VOICES];
    logic [ENV_W-1:0]     env    [VOICES];
    logic [KEY_W-1:0]     key    [VOICES];
    logic [1:0]           wave   [VOICES];

    logic          hit_found, free_found, rel_found, off_found;
    logic [VW-1:0] hit_idx, free_idx, rel_idx, off_idx, alloc_idx;

    logic                    msb;
    logic [WIDTH_P-2:0]      rest, tri_t;
    logic [WIDTH_P-1:0]      wave_val;
    logic signed [PRD_W-1:0] prod;
    logic [ENV_W:0]          env_up;

    assign note.note_ready_o = (fsm == S_IDLE);

    always_comb begin
        for (int unsigned i = 0; i < VOICES; i++) begin
            active_o[i] = (vstate[VW'(i)] != V_FREE);
        end
    end

    // Lowest-index search for retrigger target, free voice, stealable voice and note-off target.
    always_comb begin
        hit_found  = 1'b0; hit_idx  = '0;
        free_found = 1'b0; free_idx = '0;
        rel_found  = 1'b0; rel_idx  = '0;
        off_found  = 1'b0; off_idx  = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!hit_found && vstate[VW'(i)] != V_FREE && key[VW'(i)] == note.note_key_i) begin
                hit_found = 1'b1;
                hit_idx   = VW'(i);
            end
            if (!free_found && vstate[VW'(i)] == V_FREE) begin
                free_found = 1'b1;
                free_idx   = VW'(i);
            end
            if (!rel_found && vstate[VW'(i)] == V_RELEASE) begin
                rel_found = 1'b1;
                rel_idx   = VW'(i);
            end
            if (!off_found && key[VW'(i)] == note.note_key_i &&
                (vstate[VW'(i)] == V_ATTACK || vstate[VW'(i)] == V_SUSTAIN)) begin
                off_found = 1'b1;
                off_idx   = VW'(i);
            end
        end
        alloc_idx = free_found ? free_idx : rel_idx;
    end

    always_comb begin
        msb      = phase[vidx][ACC_WIDTH-1];
        rest     = phase[vidx][ACC_WIDTH-2 -: WIDTH_P-1];
        tri_t    = msb ? ~rest : rest;
        wave_val = '0;
        if (vstate[vidx] != V_FREE) begin
            case (wave[vidx])
                2'd0:    wave_val = {~msb, rest};
                2'd1:    wave_val = msb ? SQ_NEG : SQ_POS;
                2'd2:    wave_val = {~tri_t[WIDTH_P-2], tri_t[WIDTH_P-3:0], 1'b0};
                default: wave_val = '0;
            endcase
        end
        prod   = PRD_W'($signed(wave_val)) * $signed({{(WIDTH_P+1){1'b0}}, env[vidx]});
        env_up = {1'b0, env[vidx]} + (ENV_W+1)'(ATTACK_STEP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            fsm            <= S_IDLE;
            vidx           <= '0;
            acc            <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            note_drop_o    <= 1'b0;
            overrun_o      <= 1'b0;
            vstate         <= '{default: V_FREE};
            phase          <= '{default: '0};
            inc            <= '{default: '0};
            env            <= '{default: '0};
            key            <= '{default: '0};
            wave           <= '{default: '0};
        end else begin
            sample_valid_o <= 1'b0;
            note_drop_o    <= 1'b0;
            if (sample_tick_i && fsm != S_IDLE) begin
                overrun_o <= 1'b1;
            end
            case (fsm)
                S_IDLE: begin
                    if (note.note_valid_i) begin
                        if (note.note_on_i) begin
                            if (hit_found) begin
                                vstate[hit_idx] <= V_ATTACK;
                                inc[hit_idx]    <= note.note_inc_i;
                                wave[hit_idx]   <= note.note_wave_i;
                            end else if (free_found || rel_found) begin
                                vstate[alloc_idx] <= V_ATTACK;
                                phase[alloc_idx]  <= '0;
                                env[alloc_idx]    <= '0;
                                key[alloc_idx]    <= note.note_key_i;
                                inc[alloc_idx]    <= note.note_inc_i;
                                wave[alloc_idx]   <= note.note_wave_i;
                            end else begin
                                note_drop_o <= 1'b1;
                            end
                        end else if (off_found) begin
                            vstate[off_idx] <= V_RELEASE;
                        end
                    end
                    // Event writes land this edge, so the frame starting now sees them.
                    if (sample_tick_i) begin
                        acc  <= '0;
                        vidx <= '0;
                        fsm  <= S_MIX;
                    end
                end
                S_MIX: begin
                    acc <= acc + SUM_W'(prod >>> ENV_W);
                    if (vstate[vidx] != V_FREE) begin
                        phase[vidx] <= phase[vidx] + inc[vidx];
                        if (vstate[vidx] == V_ATTACK) begin
                            if (env_up >= {1'b0, ENV_MAX}) begin
                                env[vidx]    <= ENV_MAX;
                                vstate[vidx] <= V_SUSTAIN;
                            end else begin
                                env[vidx] <= env_up[ENV_W-1:0];
                            end
                        end else if (vstate[vidx] == V_RELEASE) begin
                            if ({1'b0, env[vidx]} <= (ENV_W+1)'(RELEASE_STEP)) begin
                                env[vidx]    <= '0;
                                vstate[vidx] <= V_FREE;
                            end else begin
                                env[vidx] <= env[vidx] - ENV_W'(RELEASE_STEP);
                            end
                        end
                    end
                    if (vidx == VW'(VOICES - 1)) begin
                        fsm <= S_OUT;
                    end else begin
                        vidx <= vidx + 1'b1;
                    end
                end
                S_OUT: begin
                    sample_o       <= WIDTH_P'(acc >>> VW);
                    sample_valid_o <= 1'b1;
                    fsm            <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_voice_engine.sv
// Self-checking bench for poly_voice_engine: table-driven note events plus a
// sample scoreboard fed by an integer reference model of the mixer.
module tb_poly_voice_engine;
    localparam int VOICES = 4, WIDTH_P = 24, ACC_WIDTH = 32, KEY_W = 4, ENV_W = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_tick_i = 1'b0;
    logic [WIDTH_P-1:0]   sample_o;
    logic                 sample_valid_o;
    logic [VOICES-1:0]    active_o;
    logic                 note_drop_o;
    logic                 overrun_o;

    poly_voice_engine_if #(.KEY_W(KEY_W), .ACC_WIDTH(ACC_WIDTH)) nif ();

    poly_voice_engine #(
        .VOICES(VOICES), .WIDTH_P(WIDTH_P), .ACC_WIDTH(ACC_WIDTH), .KEY_W(KEY_W),
        .ENV_W(ENV_W), .ATTACK_STEP(64), .RELEASE_STEP(32)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .note(nif), .sample_tick_i(sample_tick_i),
        .sample_o(sample_o), .sample_valid_o(sample_valid_o), .active_o(active_o),
        .note_drop_o(note_drop_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    logic [23:0] exp_q [$];
    int unsigned tq [$];
    logic [23:0] mon_e;
    int unsigned mon_t;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: states 0 free, 1 attack, 2 sustain, 3 release.
    int          m_st   [4];
    logic [31:0] m_ph   [4];
    logic [31:0] m_inc  [4];
    int          m_env  [4];
    logic [3:0]  m_key  [4];
    logic [1:0]  m_wave [4];

    function automatic void m_reset();
        for (int v = 0; v < 4; v++) begin
            m_st[v] = 0; m_ph[v] = '0; m_inc[v] = '0; m_env[v] = 0; m_key[v] = '0; m_wave[v] = '0;
        end
    endfunction

    function automatic bit m_event(bit on, logic [3:0] k, logic [31:0] inc, logic [1:0] w);
        int sel = -1;
        if (!on) begin
            for (int v = 0; v < 4; v++)
                if (sel < 0 && m_key[v] == k && (m_st[v] == 1 || m_st[v] == 2)) sel = v;
            if (sel >= 0) m_st[sel] = 3;
            return 1'b0;
        end
        for (int v = 0; v < 4; v++) if (sel < 0 && m_st[v] != 0 && m_key[v] == k) sel = v;
        if (sel >= 0) begin
            m_st[sel] = 1; m_inc[sel] = inc; m_wave[sel] = w;
            return 1'b0;
        end
        for (int v = 0; v < 4; v++) if (sel < 0 && m_st[v] == 0) sel = v;
        for (int v = 0; v < 4; v++) if (sel < 0 && m_st[v] == 3) sel = v;
        if (sel < 0) return 1'b1;
        m_st[sel] = 1; m_ph[sel] = '0; m_env[sel] = 0;
        m_key[sel] = k; m_inc[sel] = inc; m_wave[sel] = w;
        return 1'b0;
    endfunction

    function automatic logic [23:0] m_frame();
        longint acc = 0;
        longint p, w, t;
        for (int v = 0; v < 4; v++) begin
            p = longint'(m_ph[v] >> 8);
            w = 0;
            if (m_st[v] != 0) begin
                case (m_wave[v])
                    2'd0: w = p - 8388608;
                    2'd1: w = (p >= 8388608) ? -8388607 : 8388607;
                    2'd2: begin
                        t = (p >= 8388608) ? (8388607 - (p - 8388608)) : p;
                        w = 2 * t - 8388608;
                    end
                    default: w = 0;
                endcase
            end
            acc += (w * m_env[v]) >>> 8;
            if (m_st[v] != 0) begin
                m_ph[v] = m_ph[v] + m_inc[v];
                if (m_st[v] == 1) begin
                    m_env[v] += 64;
                    if (m_env[v] >= 255) begin m_env[v] = 255; m_st[v] = 2; end
                end else if (m_st[v] == 3) begin
                    m_env[v] -= 32;
                    if (m_env[v] <= 0) begin m_env[v] = 0; m_st[v] = 0; end
                end
            end
        end
        acc = acc >>> 2;
        return acc[23:0];
    endfunction

    always @(negedge clk_i) begin
        if (sample_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample_valid_o=1, expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tq.pop_front();
                check("sample", longint'(sample_o), longint'(mon_e));
                check("latency", longint'(cyc - mon_t), 5);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        m_reset();
        exp_q.delete();
        tq.delete();
    endtask

    task automatic do_tick(bit accepted);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        @(posedge clk_i);
        #1;
        if (accepted) begin
            exp_q.push_back(m_frame());
            tq.push_back(cyc);
        end
        @(negedge clk_i);
        sample_tick_i = 1'b0;
    endtask

    task automatic frame();
        do_tick(1'b1);
        repeat (6) @(posedge clk_i);
    endtask

    task automatic send(bit on, logic [3:0] k, logic [31:0] inc, logic [1:0] w,
                        logic [3:0] exp_act, bit exp_drop, string name);
        int guard = 0;
        @(negedge clk_i);
        while (!nif.note_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got note_ready_o=0, expected 1", name);
            return;
        end
        nif.note_valid_i = 1'b1; nif.note_on_i = on; nif.note_key_i = k;
        nif.note_inc_i = inc; nif.note_wave_i = w;
        @(posedge clk_i);
        void'(m_event(on, k, inc, w));
        #1;
        check({name, "_active"}, longint'(active_o), longint'(exp_act));
        check({name, "_drop"}, longint'(note_drop_o), longint'(exp_drop));
        @(negedge clk_i);
        nif.note_valid_i = 1'b0;
    endtask

    typedef struct {
        bit          on;
        logic [3:0]  key;
        logic [31:0] inc;
        logic [1:0]  wave;
        logic [3:0]  exp_act;
        bit          exp_drop;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd1, 32'h0100_0000, 2'd0, 4'b0001, 1'b0};
        vecs[1] = '{1'b1, 4'd2, 32'h0300_0000, 2'd1, 4'b0011, 1'b0};
        vecs[2] = '{1'b1, 4'd3, 32'h0050_0000, 2'd2, 4'b0111, 1'b0};
        vecs[3] = '{1'b1, 4'd4, 32'h0070_0000, 2'd3, 4'b1111, 1'b0};
        vecs[4] = '{1'b1, 4'd7, 32'h0200_0000, 2'd1, 4'b1111, 1'b1};
        vecs[5] = '{1'b0, 4'd2, 32'h0000_0000, 2'd0, 4'b1111, 1'b0};
        vecs[6] = '{1'b1, 4'd7, 32'h0200_0000, 2'd1, 4'b1111, 1'b0};
        vecs[7] = '{1'b0, 4'd9, 32'h0000_0000, 2'd0, 4'b1111, 1'b0};
        vecs[8] = '{1'b1, 4'd1, 32'h00A0_0000, 2'd2, 4'b1111, 1'b0};

        nif.note_valid_i = 1'b0; nif.note_on_i = 1'b0; nif.note_key_i = '0;
        nif.note_inc_i = '0; nif.note_wave_i = '0;
        m_reset();

        // Reset held with ticks present
        rst_n = 1'b0;
        sample_tick_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_sample", longint'(sample_o), 0);
        check("rst_active", longint'(active_o), 0);
        check("rst_valid", longint'(sample_valid_o), 0);
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_ready", longint'(nif.note_ready_o), 1);
        check("rst_overrun", longint'(overrun_o), 0);

        // Single square voice through attack
        send(1'b1, 4'd5, 32'h1000_0000, 2'd1, 4'b0001, 1'b0, "sq_on");
        repeat (5) frame();
        check("sq_5th_sample", longint'(sample_o), 24'h1FDFFF);

        // Release to free
        send(1'b0, 4'd5, 32'h0, 2'd0, 4'b0001, 1'b0, "rel_off");
        repeat (8) frame();
        check("rel_freed", longint'(active_o), 0);

        // Retrigger during release keeps phase and envelope
        send(1'b1, 4'd5, 32'h1000_0000, 2'd1, 4'b0001, 1'b0, "rt_on");
        repeat (4) frame();
        send(1'b0, 4'd5, 32'h0, 2'd0, 4'b0001, 1'b0, "rt_off");
        repeat (3) frame();
        send(1'b1, 4'd5, 32'h0123_4567, 2'd0, 4'b0001, 1'b0, "rt_retrig");
        repeat (3) frame();

        // Allocation, drop, steal, unmatched off, retrigger
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].on, vecs[i].key, vecs[i].inc, vecs[i].wave,
                 vecs[i].exp_act, vecs[i].exp_drop, $sformatf("vec%0d", i));
            if (i == 3) repeat (2) frame();
        end
        repeat (6) frame();

        // Saw wrap at half-cycle increment
        do_reset();
        send(1'b1, 4'd3, 32'h8000_0000, 2'd0, 4'b0001, 1'b0, "wrap_on");
        repeat (5) frame();

        // Triangle at phase 0 is full negative
        do_reset();
        send(1'b1, 4'd6, 32'h0, 2'd2, 4'b0001, 1'b0, "tri_on");
        repeat (2) frame();
        check("tri_phase0", longint'(sample_o), 24'hF80000);

        // Reset in the middle of a frame aborts it
        do_tick(1'b0);
        rst_n = 1'b0;
        @(posedge clk_i);
        #1;
        check("midmix_valid", longint'(sample_valid_o), 0);
        check("midmix_active", longint'(active_o), 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        m_reset();
        repeat (8) @(posedge clk_i);

        // Tick and note-on in the same idle cycle
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        nif.note_valid_i = 1'b1; nif.note_on_i = 1'b1; nif.note_key_i = 4'd2;
        nif.note_inc_i = 32'h1000_0000; nif.note_wave_i = 2'd1;
        @(posedge clk_i);
        void'(m_event(1'b1, 4'd2, 32'h1000_0000, 2'd1));
        #1;
        exp_q.push_back(m_frame());
        tq.push_back(cyc);
        check("coll_active", longint'(active_o), 4'b0001);
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        nif.note_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        frame();
        check("pre_overrun", longint'(overrun_o), 0);

        // Overrun: second tick two cycles after the first
        do_tick(1'b1);
        do_tick(1'b0);
        #1;
        check("overrun_set", longint'(overrun_o), 1);
        repeat (6) @(posedge clk_i);
        frame();
        repeat (2) frame();
        check("overrun_sticky", longint'(overrun_o), 1);

        repeat (8) @(posedge clk_i);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
